// File: rtl/n_bit_ks_subtractor_pipe.sv
// Pipelined Kogge-Stone subtractor: D = A - B - Bin, computed as A + ~B + ~Bin.
// Three register stages with a valid/ready handshake and borrow, zero and overflow flags.
module n_bit_ks_subtractor_pipe #(
    parameter int N = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [N:1] A,
    input  logic [N:1] B,
    input  logic       Bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [N:1] D,
    output logic       Bout,
    output logic       Z,
    output logic       V
);

    localparam int L = $clog2(N);
    localparam int H = (L + 1) / 2;

    // Applies KS levels first..last-1 (span 2^k). The bit loop runs from the top down,
    // so each cell reads the previous level's value of its lower neighbour.
    function automatic logic [2*N-1:0] ks_levels(
        input logic [N-1:0] gi,
        input logic [N-1:0] pi,
        input int           first,
        input int           last
    );
        logic [N-1:0] g;
        logic [N-1:0] p;
        int           span;
        int           j;
        g = gi;
        p = pi;
        for (int k = 0; k < L; k++) begin
            if (k >= first && k < last) begin
                span = 1 << k;
                for (int i = N - 1; i >= 0; i--) begin
                    if (i >= span) begin
                        j    = i - span;
                        g[i] = g[i] | (p[i] & g[j]);
                        p[i] = p[i] & p[j];
                    end
                end
            end
        end
        return {p, g};
    endfunction

    function automatic logic [N-1:0] ks_carry(
        input logic [N-1:0] gi,
        input logic [N-1:0] pi,
        input int           first,
        input int           last
    );
        logic [2*N-1:0] pg;
        pg = ks_levels(gi, pi, first, last);
        return pg[N-1:0];
    endfunction

    // handshake enables
    logic v1, v2;
    logic en1, en2, en3;

    assign en3      = ~out_valid | out_ready;
    assign en2      = ~v2 | en3;
    assign en1      = ~v1 | en2;
    assign in_ready = en1;

    // stage 0: bitwise propagate/generate of A + ~B
    logic [N-1:0] bn;
    logic [N-1:0] p0;
    logic [N-1:0] g0;

    assign bn = ~B;
    assign p0 = A ^ bn;
    assign g0 = A & bn;

    logic         s1_as, s1_bs, s1_cin;
    logic [N-1:0] s1_p, s1_g;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1     <= 1'b0;
            s1_as  <= 1'b0;
            s1_bs  <= 1'b0;
            s1_cin <= 1'b0;
            s1_p   <= '0;
            s1_g   <= '0;
        end else if (en1) begin
            v1     <= in_valid;
            s1_as  <= A[N];
            s1_bs  <= B[N];
            s1_cin <= ~Bin;
            s1_p   <= p0;
            s1_g   <= g0;
        end
    end

    // Gray cell at bit 0 folds the carry-in, so every group generate below is a true carry.
    logic [N-1:0]   g_fold;
    logic [N-1:0]   p_fold;
    logic [2*N-1:0] pg_mid;

    always_comb begin
        g_fold    = s1_g;
        p_fold    = s1_p;
        g_fold[0] = s1_g[0] | (s1_p[0] & s1_cin);
        p_fold[0] = 1'b0;
    end

    assign pg_mid = ks_levels(g_fold, p_fold, 0, H);

    logic         s2_as, s2_bs, s2_cin;
    logic [N-1:0] s2_p, s2_g, s2_pg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2     <= 1'b0;
            s2_as  <= 1'b0;
            s2_bs  <= 1'b0;
            s2_cin <= 1'b0;
            s2_p   <= '0;
            s2_g   <= '0;
            s2_pg  <= '0;
        end else if (en2) begin
            v2     <= v1;
            s2_as  <= s1_as;
            s2_bs  <= s1_bs;
            s2_cin <= s1_cin;
            s2_p   <= s1_p;
            s2_g   <= pg_mid[N-1:0];
            s2_pg  <= pg_mid[2*N-1:N];
        end
    end

    // remaining prefix levels, sum and flags
    logic [N-1:0] carry;
    logic [N-1:0] sum;
    logic         cout;
    logic         zero;
    logic         ovf;

    assign carry = ks_carry(s2_g, s2_pg, H, L);
    assign sum   = s2_p ^ {carry[N-2:0], s2_cin};
    assign cout  = carry[N-1];
    assign zero  = (sum == '0);
    assign ovf   = (s2_as != s2_bs) && (sum[N-1] != s2_as);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            D         <= '0;
            Bout      <= 1'b0;
            Z         <= 1'b0;
            V         <= 1'b0;
        end else if (en3) begin
            out_valid <= v2;
            D         <= sum;
            Bout      <= ~cout;
            Z         <= zero;
            V         <= ovf;
        end
    end

endmodule

// File: tb/tb_n_bit_ks_subtractor_pipe.sv
// Directed and randomized checks of the pipelined KS subtractor at N=32 and N=8.
module tb_n_bit_ks_subtractor_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        iv, ir, ov, ordy, bin, bout, z, v;
    logic [32:1] a, b, d;
    logic        iv8, ir8, ov8, ordy8, bin8, bout8, z8, v8;
    logic [8:1]  a8, b8, d8;

    int errors = 0;
    int checks = 0;

    n_bit_ks_subtractor_pipe #(.N(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir),
        .A(a), .B(b), .Bin(bin), .out_valid(ov), .out_ready(ordy),
        .D(d), .Bout(bout), .Z(z), .V(v)
    );

    n_bit_ks_subtractor_pipe #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .Bin(bin8), .out_valid(ov8), .out_ready(ordy8),
        .D(d8), .Bout(bout8), .Z(z8), .V(v8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {bout, z, v, d}
    function automatic logic [34:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic bi);
        logic [32:0] r;
        logic [31:0] dd;
        r  = {1'b0, x} - {1'b0, y} - {32'b0, bi};
        dd = r[31:0];
        return {r[32], dd == 32'd0, (x[31] != y[31]) && (dd[31] != x[31]), dd};
    endfunction

    function automatic logic [10:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic bi);
        logic [8:0] r;
        logic [7:0] dd;
        r  = {1'b0, x} - {1'b0, y} - {8'b0, bi};
        dd = r[7:0];
        return {r[8], dd == 8'd0, (x[7] != y[7]) && (dd[7] != x[7]), dd};
    endfunction

    function automatic logic [31:0] opa(input int j);
        return 32'(j) * 32'h2345_6789 + 32'd7;
    endfunction

    function automatic logic [31:0] opb(input int j);
        return 32'h1111_1111 * 32'(8 - j);
    endfunction

    // single operand, consumer ready: visible on the third edge after it is presented
    task automatic run1(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                        input logic xbin, input logic [31:0] ed, input logic eb,
                        input logic ez, input logic ev);
        a = xa; b = xb; bin = xbin; iv = 1'b1;
        tick();
        iv = 1'b0;
        tick();
        chk({tag, ".early_valid"}, 64'(ov), 64'd0);
        tick();
        chk({tag, ".valid"}, 64'(ov), 64'd1);
        chk({tag, ".d"}, 64'(d), 64'(ed));
        chk({tag, ".bout"}, 64'(bout), 64'(eb));
        chk({tag, ".z"}, 64'(z), 64'(ez));
        chk({tag, ".v"}, 64'(v), 64'(ev));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [34:0] q32[$];
    logic [10:0] q8[$];

    initial begin
        reset = 1'b1;
        iv = 1'b0; ordy = 1'b1; a = '0; b = '0; bin = 1'b0;
        iv8 = 1'b0; ordy8 = 1'b1; a8 = '0; b8 = '0; bin8 = 1'b0;
        #12;
        chk("reset.out_valid", 64'(ov), 64'd0);
        chk("reset.d", 64'(d), 64'd0);
        chk("reset.bout", 64'(bout), 64'd0);
        chk("reset.z", 64'(z), 64'd0);
        chk("reset.v", 64'(v), 64'd0);
        chk("reset.out_valid8", 64'(ov8), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset.in_ready", 64'(ir), 64'd1);
        tick();

        run1("t1", 32'd75, 32'd25, 1'b0, 32'd50, 1'b0, 1'b0, 1'b0);
        run1("t2.neg", 32'd25, 32'd75, 1'b0, 32'hFFFF_FFCE, 1'b1, 1'b0, 1'b0);
        run1("t2.zero_bin", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run1("t2.eq", 32'h1234, 32'h1234, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        run1("t2.self_bin", 32'd5, 32'd5, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run1("t3.ovf_a", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        run1("t3.ovf_b", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);

        // back-to-back stream
        for (int t = 0; t <= 10; t++) begin
            if (t < 8) begin
                a = opa(t); b = opb(t); bin = logic'(t & 1); iv = 1'b1;
            end else begin
                iv = 1'b0;
            end
            tick();
            if (t >= 2 && t < 10) begin
                chk($sformatf("t4.valid%0d", t), 64'(ov), 64'd1);
                chk($sformatf("t4.res%0d", t), 64'({bout, z, v, d}),
                    64'(ref32(opa(t - 2), opb(t - 2), logic'((t - 2) & 1))));
            end else begin
                chk($sformatf("t4.idle%0d", t), 64'(ov), 64'd0);
            end
        end

        // stalled consumer: three accepts fill the pipe, then hold
        ordy = 1'b0;
        for (int t = 0; t < 6; t++) begin
            a = 32'(1000 + 3 * t); b = 32'(500 * t); bin = logic'(t & 1); iv = 1'b1;
            #1;
            chk($sformatf("t5.in_ready%0d", t), 64'(ir), 64'(t < 3));
            tick();
            if (t >= 2) begin
                chk($sformatf("t5.hold_valid%0d", t), 64'(ov), 64'd1);
                chk($sformatf("t5.hold%0d", t), 64'({bout, z, v, d}), 64'(ref32(32'd1000, 32'd0, 1'b0)));
            end
        end
        iv = 1'b0; ordy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            if (r < 3) begin
                chk($sformatf("t5.drain_valid%0d", r), 64'(ov), 64'd1);
                chk($sformatf("t5.drain%0d", r), 64'({bout, z, v, d}),
                    64'(ref32(32'(1000 + 3 * r), 32'(500 * r), logic'(r & 1))));
            end else begin
                chk("t5.drain_empty", 64'(ov), 64'd0);
            end
            tick();
        end
        chk("t5.in_ready_after", 64'(ir), 64'd1);

        // reset with results in flight
        ordy = 1'b0;
        for (int t = 0; t < 3; t++) begin
            a = 32'(200 + t); b = 32'd3; bin = 1'b0; iv = 1'b1;
            tick();
        end
        iv = 1'b0;
        chk("t6.pre_valid", 64'(ov), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6.async_valid", 64'(ov), 64'd0);
        chk("t6.async_d", 64'(d), 64'd0);
        #1 reset = 1'b0;
        ordy = 1'b1;
        run1("t6.new", 32'd9, 32'd4, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t6.no_stale", 64'(ov), 64'd0);

        // randomized traffic on both widths
        for (int c = 0; c < 3000; c++) begin
            a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom; bin = 1'($urandom_range(0, 1));
            iv = ($urandom_range(0, 3) != 0); ordy = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = ($urandom_range(0, 3) == 0) ? a8 : 8'($urandom); bin8 = 1'($urandom_range(0, 1));
            iv8 = ($urandom_range(0, 3) != 0); ordy8 = ($urandom_range(0, 3) != 0);
            #1;
            if (ov && ordy) begin
                if (q32.size() == 0) chk("rnd32.unexpected", 64'(ov), 64'd0);
                else chk("rnd32.res", 64'({bout, z, v, d}), 64'(q32.pop_front()));
            end
            if (iv && ir) q32.push_back(ref32(a, b, bin));
            if (ov8 && ordy8) begin
                if (q8.size() == 0) chk("rnd8.unexpected", 64'(ov8), 64'd0);
                else chk("rnd8.res", 64'({bout8, z8, v8, d8}), 64'(q8.pop_front()));
            end
            if (iv8 && ir8) q8.push_back(ref8(a8, b8, bin8));
            tick();
        end
        iv = 1'b0; ordy = 1'b1; iv8 = 1'b0; ordy8 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (ov) begin
                if (q32.size() == 0) chk("rnd32.unexpected", 64'(ov), 64'd0);
                else chk("rnd32.res", 64'({bout, z, v, d}), 64'(q32.pop_front()));
            end
            if (ov8) begin
                if (q8.size() == 0) chk("rnd8.unexpected", 64'(ov8), 64'd0);
                else chk("rnd8.res", 64'({bout8, z8, v8, d8}), 64'(q8.pop_front()));
            end
            tick();
        end
        chk("rnd32.drained", 64'(q32.size()), 64'd0);
        chk("rnd8.drained", 64'(q8.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
